// File: rtl/dccm_mmio_console_pkg.sv
// Shared constants and types for the DCCM simulation-control MMIO sink:
// the tohost/console addresses and the UART transmitter state encoding.
package dccm_mmio_console_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] TOHOST_ADDR  = 32'h1000_0000;
    localparam logic [XLEN-1:0] CONSOLE_ADDR = 32'h1000_0004;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/dccm_mmio_console_fifo.sv
// Circular byte FIFO for queued console characters. A pop on the same edge
// frees the slot, so "full" is reported only when no pop is in progress.
module mmio_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == {CNT_W{1'b0}});
    assign full      = (count_r == CNT_FULL) & ~pop;
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign pop_data  = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dccm_mmio_console.sv
// Device end of the tohost/finish protocol: decodes DCCM stores, latches the
// exit code on the first tohost write, and serializes console bytes as UART 8N1.
module dccm_mmio_console
    import dccm_mmio_console_pkg::*;
#(
    parameter int              XLEN         = dccm_mmio_console_pkg::XLEN,
    parameter logic [XLEN-1:0] TOHOST_ADDR  = dccm_mmio_console_pkg::TOHOST_ADDR,
    parameter logic [XLEN-1:0] CONSOLE_ADDR = dccm_mmio_console_pkg::CONSOLE_ADDR,
    parameter int              FIFO_DEPTH   = 8,
    parameter int              CLKS_PER_BIT = 868
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dccm_wen,
    input  logic [XLEN-1:0] dccm_waddr,
    input  logic [XLEN-1:0] dccm_wdata,
    output logic            uart_tx,
    output logic            halt,
    output logic [XLEN-1:0] exit_code,
    output logic            halt_done,
    output logic            console_overflow
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int TIMER_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};

    logic            halt_r;
    logic [XLEN-1:0] exit_code_r;
    logic            halt_done_r;
    logic            overflow_r;

    logic            tohost_wr_s;
    logic            console_wr_s;
    logic            fifo_push_s;
    logic            fifo_pop_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [7:0]      fifo_data_s;
    logic [CNT_W-1:0] fifo_count_s;

    uart_tx_state_e   state_r, state_nx_s;
    logic [TIMER_W-1:0] timer_r, timer_nx_s;
    logic [2:0]       idx_r, idx_nx_s;
    logic [7:0]       shift_r, shift_nx_s;
    logic             uart_tx_r, tx_nx_s;
    logic             bit_end_s;

    // Stores are ignored entirely once halted, including overflow accounting.
    assign tohost_wr_s  = dccm_wen & (dccm_waddr == TOHOST_ADDR) & ~halt_r;
    assign console_wr_s = dccm_wen & (dccm_waddr == CONSOLE_ADDR) & ~halt_r;
    assign fifo_push_s  = console_wr_s & ~fifo_full_s;
    assign bit_end_s    = (timer_r == TIMER_LAST);

    mmio_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push_s),
        .push_data (dccm_wdata[7:0]),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_data_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Halt/exit latch, sticky overflow flag and drained-halt indicator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halt_r      <= 1'b0;
            exit_code_r <= {XLEN{1'b0}};
            overflow_r  <= 1'b0;
            halt_done_r <= 1'b0;
        end else begin
            if (tohost_wr_s) begin
                halt_r      <= 1'b1;
                exit_code_r <= dccm_wdata;
            end
            overflow_r  <= overflow_r | (console_wr_s & fifo_full_s);
            halt_done_r <= halt_r & (fifo_count_s == {CNT_W{1'b0}}) & (state_r == TX_IDLE);
        end
    end

    // UART transmitter state and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= TX_IDLE;
            timer_r   <= TIMER_ZERO;
            idx_r     <= 3'd0;
            shift_r   <= 8'h00;
            uart_tx_r <= 1'b1;
        end else begin
            state_r   <= state_nx_s;
            timer_r   <= timer_nx_s;
            idx_r     <= idx_nx_s;
            shift_r   <= shift_nx_s;
            uart_tx_r <= tx_nx_s;
        end
    end

    // Next-state logic; tx_nx_s is the line level for the cycle after the edge.
    always_comb begin
        state_nx_s = state_r;
        timer_nx_s = timer_r;
        idx_nx_s   = idx_r;
        shift_nx_s = shift_r;
        tx_nx_s    = 1'b1;
        fifo_pop_s = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    shift_nx_s = fifo_data_s;
                    timer_nx_s = TIMER_ZERO;
                    idx_nx_s   = 3'd0;
                    state_nx_s = TX_START;
                    tx_nx_s    = 1'b0;
                end else begin
                    tx_nx_s = 1'b1;
                end
            end
            TX_START: begin
                if (bit_end_s) begin
                    timer_nx_s = TIMER_ZERO;
                    state_nx_s = TX_DATA;
                    tx_nx_s    = shift_r[0];
                end else begin
                    timer_nx_s = timer_r + TIMER_ONE;
                    tx_nx_s    = 1'b0;
                end
            end
            TX_DATA: begin
                if (bit_end_s) begin
                    timer_nx_s = TIMER_ZERO;
                    if (idx_r == 3'd7) begin
                        state_nx_s = TX_STOP;
                        tx_nx_s    = 1'b1;
                    end else begin
                        idx_nx_s   = idx_r + 3'd1;
                        shift_nx_s = {1'b0, shift_r[7:1]};
                        tx_nx_s    = shift_r[1];
                    end
                end else begin
                    timer_nx_s = timer_r + TIMER_ONE;
                    tx_nx_s    = shift_r[0];
                end
            end
            TX_STOP: begin
                tx_nx_s = 1'b1;
                if (bit_end_s) begin
                    timer_nx_s = TIMER_ZERO;
                    state_nx_s = TX_IDLE;
                end else begin
                    timer_nx_s = timer_r + TIMER_ONE;
                end
            end
            default: begin
                state_nx_s = TX_IDLE;
                tx_nx_s    = 1'b1;
            end
        endcase
    end

    assign uart_tx          = uart_tx_r;
    assign halt             = halt_r;
    assign exit_code        = exit_code_r;
    assign halt_done        = halt_done_r;
    assign console_overflow = overflow_r;

endmodule

// File: tb/tb_dccm_mmio_console.sv
// Scoreboard bench for dccm_mmio_console: a cycle-level model predicts accepted
// bytes and their frame start times; a UART monitor decodes the line and compares.
module tb_dccm_mmio_console;
    import dccm_mmio_console_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam int INF   = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dccm_wen = 1'b0;
    logic [31:0] dccm_waddr = 32'h0;
    logic [31:0] dccm_wdata = 32'h0;
    logic        uart_tx;
    logic        halt;
    logic [31:0] exit_code;
    logic        halt_done;
    logic        console_overflow;

    dccm_mmio_console #(
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dccm_wen         (dccm_wen),
        .dccm_waddr       (dccm_waddr),
        .dccm_wdata       (dccm_wdata),
        .uart_tx          (uart_tx),
        .halt             (halt),
        .exit_code        (exit_code),
        .halt_done        (halt_done),
        .console_overflow (console_overflow)
    );

    always #5 clk = ~clk;

    // cyc == k between posedge k and posedge k+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_at_edge_r = 1'b1;
    always @(posedge clk) rst_at_edge_r <= ~rst_n;

    typedef struct {
        logic [7:0] data;
        int         pop_edge;
    } frame_t;

    frame_t      sb_q[$];
    int          pops_q[$];
    int          halt_edge;
    int          ovf_edge;
    int          last_pop;
    logic [31:0] exp_exit;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic void model_reset();
        halt_edge = INF;
        ovf_edge  = INF;
        last_pop  = -1000;
        exp_exit  = 32'h0;
        pops_q.delete();
        sb_q.delete();
    endfunction

    function automatic void check1(string nm, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    function automatic void check32(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one store and updates the reference model for the edge that samples it.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        int e;
        int occ;
        int pop_now;
        int p;
        e = cyc + 1;
        dccm_wen   = 1'b1;
        dccm_waddr = addr;
        dccm_wdata = data;
        if (halt_edge == INF && addr == TOHOST_ADDR) begin
            halt_edge = e;
            exp_exit  = data;
        end else if (halt_edge == INF && addr == CONSOLE_ADDR) begin
            occ = 0;
            pop_now = 0;
            foreach (pops_q[i]) begin
                if (pops_q[i] >= e) occ++;
                if (pops_q[i] == e) pop_now = 1;
            end
            if (occ - pop_now < DEPTH) begin
                p = (e + 1 > last_pop + FRAME + 1) ? e + 1 : last_pop + FRAME + 1;
                last_pop = p;
                pops_q.push_back(p);
                sb_q.push_back('{data[7:0], p});
            end else if (ovf_edge == INF) begin
                ovf_edge = e;
            end
        end
        @(posedge clk);
        #1;
        dccm_wen = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = last_pop + FRAME + 4 - cyc;
        idle((w < 1) ? 1 : w);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(2);
    endtask

    // Monitor: status checks every cycle plus UART frame decoding at mid-bit.
    initial begin : monitor
        int in_frame;
        int f_start;
        int off;
        int j;
        int hd;
        logic [7:0] f_data;
        frame_t exp_f;
        in_frame = 0;
        f_start  = 0;
        f_data   = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_at_edge_r) begin
                in_frame = 0;
                check1("rst_uart_tx", uart_tx, 1'b1);
                check1("rst_halt", halt, 1'b0);
                check32("rst_exit_code", exit_code, 32'h0);
                check1("rst_halt_done", halt_done, 1'b0);
                check1("rst_overflow", console_overflow, 1'b0);
            end else begin
                check1("halt", halt, cyc >= halt_edge);
                check32("exit_code", exit_code, (cyc >= halt_edge) ? exp_exit : 32'h0);
                check1("overflow", console_overflow, cyc >= ovf_edge);
                hd = (halt_edge + 1 > last_pop + FRAME + 1) ? halt_edge + 1 : last_pop + FRAME + 1;
                if (cyc != last_pop + FRAME) check1("halt_done", halt_done, cyc >= hd);
                if (in_frame == 0 && uart_tx === 1'b0) begin
                    in_frame = 1;
                    f_start  = cyc;
                end
                if (in_frame != 0) begin
                    off = cyc - f_start;
                    if (off % CPB == CPB / 2) begin
                        j = off / CPB;
                        if (j == 0) begin
                            check1("start_bit", uart_tx, 1'b0);
                        end else if (j <= 8) begin
                            f_data[j-1] = uart_tx;
                        end else begin
                            check1("stop_bit", uart_tx, 1'b1);
                            in_frame = 0;
                            if (sb_q.size() == 0) begin
                                n_cmp++;
                                n_bad++;
                                $display("FAIL unexpected_frame: got byte %h expected no frame at cycle %0d", f_data, cyc);
                            end else begin
                                exp_f = sb_q.pop_front();
                                check32("frame_byte", {24'h0, f_data}, {24'h0, exp_f.data});
                                check32("frame_start", f_start, exp_f.pop_edge);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #(100000 * 10);
        $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stimulus
        int r;
        logic [31:0] d;
        model_reset();
        rst_n = 1'b0;
        idle(10);
        rst_n = 1'b1;
        idle(3);

        // Single byte 'A'.
        do_write(CONSOLE_ADDR, 32'h0000_0041);
        idle(60);

        // Six back-to-back bytes into a four-deep FIFO.
        for (int i = 0; i < 6; i++) do_write(CONSOLE_ADDR, 32'h30 + 32'(i));
        drain();
        reset_dut();

        // Random traffic, including near-miss addresses and bursts.
        repeat (40) begin
            r = $urandom_range(0, 9);
            d = $urandom;
            if (r < 7) do_write(CONSOLE_ADDR, d);
            else if (r == 7) do_write(CONSOLE_ADDR + 32'd4, d);
            else if (r == 8) do_write(TOHOST_ADDR | 32'h8000_0000, d);
            else do_write(CONSOLE_ADDR ^ 32'h0000_0100, d);
            idle(($urandom_range(0, 3) == 0) ? $urandom_range(30, 90) : $urandom_range(0, 6));
        end
        drain();
        reset_dut();

        // Halt while a byte is still being sent, then post-halt stores.
        do_write(CONSOLE_ADDR, 32'h0000_0048);
        do_write(TOHOST_ADDR, 32'h0000_0001);
        idle(10);
        do_write(TOHOST_ADDR, 32'h0000_DEAD);
        do_write(CONSOLE_ADDR, 32'h0000_005A);
        drain();
        idle(20);
        reset_dut();

        // Reset during data bit 3, then a clean frame.
        do_write(CONSOLE_ADDR, 32'h0000_00F0);
        idle(18);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        idle(1);
        rst_n = 1'b1;
        idle(2);
        do_write(CONSOLE_ADDR, 32'h0000_00A5);
        drain();
        idle(5);

        check32("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
